// File: rtl/wb_sdram_txn_monitor.sv
// Passive whitebox monitor for the SDRAM controller.
// It observes the Wishbone slave port and the SDRAM command pins, follows each transaction
// through a small FSM, and keeps saturating event counters and first-beat latency figures.
// It also raises sticky flags for protocol errors and hung requests.
// The monitor never drives the observed design.
module wb_sdram_txn_monitor #(
    parameter int unsigned AW      = 26,
    parameter int unsigned DW      = 32,
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned LAT_W   = 10,
    parameter int unsigned TIMEOUT = 256
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,      // active-low, asynchronous
    input  logic              clr_i,
    input  logic              wb_cyc_i,
    input  logic              wb_stb_i,
    input  logic              wb_we_i,
    input  logic              wb_ack_o,      // slave ack, observed only
    input  logic [2:0]        wb_cti_i,
    input  logic [AW-1:0]     wb_addr_i,
    input  logic [DW/8-1:0]   wb_sel_i,
    input  logic              sdram_en,
    input  logic              sdram_ras_n,
    input  logic              sdram_cas_n,
    input  logic              sdram_we_n,
    output logic [CNT_W-1:0]  rd_cnt_o,
    output logic [CNT_W-1:0]  wr_cnt_o,
    output logic [CNT_W-1:0]  beat_cnt_o,
    output logic [CNT_W-1:0]  act_cnt_o,
    output logic [CNT_W-1:0]  ref_cnt_o,
    output logic [LAT_W-1:0]  lat_last_o,
    output logic [LAT_W-1:0]  lat_max_o,
    output logic              busy_o,
    output logic              timeout_o,
    output logic              err_o,
    output logic [2:0]        err_code_o
);

    localparam int unsigned SW = DW / 8;
    localparam logic [AW-1:0]  STRIDE     = AW'(SW);
    localparam logic [LAT_W:0] TIMEOUT_LV = (LAT_W + 1)'(TIMEOUT);
    localparam logic [2:0]     CTI_INC    = 3'b010;
    localparam logic [2:0]     CTI_END    = 3'b111;

    typedef enum logic [1:0] {StIdle, StReq, StBurst, StHung} state_t;

    // FSM and transaction snapshot
    state_t            r_state, w_state_d;
    logic [LAT_W-1:0]  r_lat, w_lat_d;
    logic [AW-1:0]     r_addr, w_addr_d;
    logic              r_we, w_we_d;
    logic [SW-1:0]     r_sel, w_sel_d;
    logic [AW-1:0]     r_exp, w_exp_d;

    // Output registers
    logic [CNT_W-1:0]  r_rd_cnt, r_wr_cnt, r_beat_cnt, r_act_cnt, r_ref_cnt;
    logic [LAT_W-1:0]  r_lat_last, r_lat_max;
    logic              r_timeout, r_err;
    logic [2:0]        r_err_code;

    // Per-cycle events
    logic              w_req;
    logic              w_beat, w_done_rd, w_done_wr, w_lat_smp, w_timeout;
    logic [LAT_W-1:0]  w_lat_val;
    logic [LAT_W:0]    w_lat_inc;
    logic [5:1]        w_err;
    logic [2:0]        w_err_code;
    logic [2:0]        w_cmd;
    logic              w_act, w_ref;

    function automatic logic [CNT_W-1:0] sat_cnt(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign w_req     = wb_cyc_i & wb_stb_i;
    assign w_cmd     = {sdram_ras_n, sdram_cas_n, sdram_we_n};
    assign w_act     = sdram_en & (w_cmd == 3'b011);
    assign w_ref     = sdram_en & (w_cmd == 3'b001);
    assign w_lat_inc = {1'b0, r_lat} + (LAT_W + 1)'(1);

    // Next-state, snapshot updates and event/error detection
    always_comb begin
        w_state_d = r_state;
        w_lat_d   = r_lat;
        w_addr_d  = r_addr;
        w_we_d    = r_we;
        w_sel_d   = r_sel;
        w_exp_d   = r_exp;
        w_beat    = 1'b0;
        w_done_rd = 1'b0;
        w_done_wr = 1'b0;
        w_lat_smp = 1'b0;
        w_lat_val = '0;
        w_timeout = 1'b0;
        w_err     = '0;

        if (wb_ack_o && !w_req) begin
            w_err[1] = 1'b1;
        end
        // READ (101) or WRITE (100) while no transaction is open
        if (sdram_en && (r_state == StIdle) && (w_cmd[2:1] == 2'b10)) begin
            w_err[5] = 1'b1;
        end

        unique case (r_state)
            StIdle: begin
                if (w_req) begin
                    w_addr_d  = wb_addr_i;
                    w_we_d    = wb_we_i;
                    w_sel_d   = wb_sel_i;
                    w_lat_d   = LAT_W'(1);
                    w_state_d = StReq;
                    // Zero-wait ack: the first beat completes in this same cycle
                    if (wb_ack_o) begin
                        w_beat    = 1'b1;
                        w_lat_smp = 1'b1;
                        w_lat_val = LAT_W'(1);
                        if (wb_cti_i == CTI_INC) begin
                            w_state_d = StBurst;
                            w_exp_d   = wb_addr_i + STRIDE;
                        end else begin
                            w_state_d = StIdle;
                            w_done_wr = wb_we_i;
                            w_done_rd = ~wb_we_i;
                        end
                    end
                end
            end
            StReq: begin
                if (!wb_cyc_i) begin
                    w_state_d = StIdle;
                end else if (w_req && wb_ack_o) begin
                    w_beat    = 1'b1;
                    w_lat_smp = 1'b1;
                    w_lat_val = r_lat;
                    if (wb_cti_i == CTI_INC) begin
                        w_state_d = StBurst;
                        w_exp_d   = r_addr + STRIDE;
                    end else begin
                        w_state_d = StIdle;
                        w_done_wr = r_we;
                        w_done_rd = ~r_we;
                    end
                end else begin
                    if (w_req && ((wb_addr_i != r_addr) || (wb_we_i != r_we) ||
                                  (wb_sel_i != r_sel))) begin
                        w_err[2] = 1'b1;
                    end
                    w_lat_d = (&r_lat) ? r_lat : w_lat_inc[LAT_W-1:0];
                    // The counter reaches TIMEOUT on this edge: flag it now
                    if (w_lat_inc >= TIMEOUT_LV) begin
                        w_timeout = 1'b1;
                        w_state_d = StHung;
                    end
                end
            end
            StBurst: begin
                if (!wb_cyc_i) begin
                    w_err[4]  = 1'b1;
                    w_state_d = StIdle;
                end else if (w_req && wb_ack_o) begin
                    w_beat  = 1'b1;
                    w_exp_d = r_exp + STRIDE;
                    if (wb_addr_i != r_exp) begin
                        w_err[3] = 1'b1;
                    end
                    if (wb_cti_i == CTI_END) begin
                        w_state_d = StIdle;
                        w_done_wr = r_we;
                        w_done_rd = ~r_we;
                    end
                end
            end
            StHung: begin
                // A late ack is a protocol error and is never counted
                if (wb_ack_o) begin
                    w_err[1] = 1'b1;
                end
                if (!wb_cyc_i) begin
                    w_state_d = StIdle;
                end
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    // Lowest error code wins when several fire together
    always_comb begin
        w_err_code = 3'd0;
        if (w_err[1]) begin
            w_err_code = 3'd1;
        end else if (w_err[2]) begin
            w_err_code = 3'd2;
        end else if (w_err[3]) begin
            w_err_code = 3'd3;
        end else if (w_err[4]) begin
            w_err_code = 3'd4;
        end else if (w_err[5]) begin
            w_err_code = 3'd5;
        end
    end

    // FSM state register
    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    // Latency counter and transaction snapshot; untouched by clr_i
    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            r_lat  <= '0;
            r_addr <= '0;
            r_we   <= 1'b0;
            r_sel  <= '0;
            r_exp  <= '0;
        end else begin
            r_lat  <= w_lat_d;
            r_addr <= w_addr_d;
            r_we   <= w_we_d;
            r_sel  <= w_sel_d;
            r_exp  <= w_exp_d;
        end
    end

    // Counters, latency results and sticky flags; clr_i overrides same-cycle events
    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            r_rd_cnt   <= '0;
            r_wr_cnt   <= '0;
            r_beat_cnt <= '0;
            r_act_cnt  <= '0;
            r_ref_cnt  <= '0;
            r_lat_last <= '0;
            r_lat_max  <= '0;
            r_timeout  <= 1'b0;
            r_err      <= 1'b0;
            r_err_code <= 3'd0;
        end else if (clr_i) begin
            r_rd_cnt   <= '0;
            r_wr_cnt   <= '0;
            r_beat_cnt <= '0;
            r_act_cnt  <= '0;
            r_ref_cnt  <= '0;
            r_lat_last <= '0;
            r_lat_max  <= '0;
            r_timeout  <= 1'b0;
            r_err      <= 1'b0;
            r_err_code <= 3'd0;
        end else begin
            if (w_done_rd) r_rd_cnt <= sat_cnt(r_rd_cnt);
            if (w_done_wr) r_wr_cnt <= sat_cnt(r_wr_cnt);
            if (w_beat)    r_beat_cnt <= sat_cnt(r_beat_cnt);
            if (w_act)     r_act_cnt <= sat_cnt(r_act_cnt);
            if (w_ref)     r_ref_cnt <= sat_cnt(r_ref_cnt);
            if (w_lat_smp) begin
                r_lat_last <= w_lat_val;
                if (w_lat_val > r_lat_max) begin
                    r_lat_max <= w_lat_val;
                end
            end
            if (w_timeout) r_timeout <= 1'b1;
            if ((|w_err) && !r_err) begin
                r_err      <= 1'b1;
                r_err_code <= w_err_code;
            end
        end
    end

    assign rd_cnt_o   = r_rd_cnt;
    assign wr_cnt_o   = r_wr_cnt;
    assign beat_cnt_o = r_beat_cnt;
    assign act_cnt_o  = r_act_cnt;
    assign ref_cnt_o  = r_ref_cnt;
    assign lat_last_o = r_lat_last;
    assign lat_max_o  = r_lat_max;
    assign busy_o     = (r_state != StIdle);
    assign timeout_o  = r_timeout;
    assign err_o      = r_err;
    assign err_code_o = r_err_code;

endmodule

// File: tb/tb_wb_sdram_txn_monitor.sv
// Directed bench for wb_sdram_txn_monitor.
// A default instance covers the main behaviour.
// A second instance with CNT_W=4 checks counter saturation.
module tb_wb_sdram_txn_monitor;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clr;
    logic        cyc, stb, we, ack;
    logic [2:0]  cti;
    logic [25:0] addr;
    logic [3:0]  sel;
    logic        sd_en, ras_n, cas_n, we_n;

    logic [15:0] rd_cnt, wr_cnt, beat_cnt, act_cnt, ref_cnt;
    logic [9:0]  lat_last, lat_max;
    logic        busy, tmo, err;
    logic [2:0]  code;

    logic [3:0]  s_rd, s_wr, s_beat, s_act, s_ref;
    logic [9:0]  s_lat_last, s_lat_max;
    logic        s_busy, s_tmo, s_err;
    logic [2:0]  s_code;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    wb_sdram_txn_monitor dut (
        .wb_clk_i(clk), .wb_rst_i(rst_n), .clr_i(clr),
        .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we), .wb_ack_o(ack),
        .wb_cti_i(cti), .wb_addr_i(addr), .wb_sel_i(sel),
        .sdram_en(sd_en), .sdram_ras_n(ras_n), .sdram_cas_n(cas_n), .sdram_we_n(we_n),
        .rd_cnt_o(rd_cnt), .wr_cnt_o(wr_cnt), .beat_cnt_o(beat_cnt),
        .act_cnt_o(act_cnt), .ref_cnt_o(ref_cnt),
        .lat_last_o(lat_last), .lat_max_o(lat_max),
        .busy_o(busy), .timeout_o(tmo), .err_o(err), .err_code_o(code)
    );

    wb_sdram_txn_monitor #(.CNT_W(4)) dut_s (
        .wb_clk_i(clk), .wb_rst_i(rst_n), .clr_i(clr),
        .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we), .wb_ack_o(ack),
        .wb_cti_i(cti), .wb_addr_i(addr), .wb_sel_i(sel),
        .sdram_en(sd_en), .sdram_ras_n(ras_n), .sdram_cas_n(cas_n), .sdram_we_n(we_n),
        .rd_cnt_o(s_rd), .wr_cnt_o(s_wr), .beat_cnt_o(s_beat),
        .act_cnt_o(s_act), .ref_cnt_o(s_ref),
        .lat_last_o(s_lat_last), .lat_max_o(s_lat_max),
        .busy_o(s_busy), .timeout_o(s_tmo), .err_o(s_err), .err_code_o(s_code)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic bus_idle();
        cyc = 1'b0; stb = 1'b0; we = 1'b0; ack = 1'b0; cti = 3'b000;
    endtask

    task automatic do_clr();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    task automatic sd_cmd(input logic [2:0] c);
        sd_en = 1'b1;
        {ras_n, cas_n, we_n} = c;
        tick();
        sd_en = 1'b0;
        {ras_n, cas_n, we_n} = 3'b111;
    endtask

    initial begin
        rst_n = 1'b0; clr = 1'b0;
        bus_idle();
        addr = '0; sel = 4'hF;
        sd_en = 1'b0; {ras_n, cas_n, we_n} = 3'b111;
        tick();
        tick();
        chk("reset_busy", busy, 0);
        chk("reset_rd", rd_cnt, 0);
        chk("reset_code", code, 0);
        rst_n = 1'b1;
        tick();

        // Reset in the middle of a request
        cyc = 1'b1; stb = 1'b1; addr = 26'h40;
        repeat (5) tick();
        chk("midreq_busy", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_busy", busy, 0);
        chk("async_rst_beat", beat_cnt, 0);
        bus_idle();
        tick();
        rst_n = 1'b1;
        tick();

        // Single read, ack on the 4th cycle of the request -> latency 3
        cyc = 1'b1; stb = 1'b1; we = 1'b0; addr = 26'h80;
        repeat (3) tick();
        ack = 1'b1;
        tick();
        bus_idle();
        chk("rd1_rd", rd_cnt, 1);
        chk("rd1_lat_last", lat_last, 3);
        chk("rd1_lat_max", lat_max, 3);
        chk("rd1_busy", busy, 0);
        tick();

        // Zero-wait single write; lat_max keeps the earlier 3
        cyc = 1'b1; stb = 1'b1; we = 1'b1; ack = 1'b1; addr = 26'h200;
        tick();
        bus_idle();
        chk("wr_wr", wr_cnt, 1);
        chk("wr_beat", beat_cnt, 2);
        chk("wr_lat_last", lat_last, 1);
        chk("wr_lat_max", lat_max, 3);
        chk("wr_busy", busy, 0);
        tick();
        chk("wr_err", err, 0);
        do_clr();
        chk("clr_wr", wr_cnt, 0);
        chk("clr_lat_max", lat_max, 0);

        // 4-beat incrementing read burst at 0x100
        cyc = 1'b1; stb = 1'b1; we = 1'b0; ack = 1'b1; cti = 3'b010;
        addr = 26'h100; tick();
        chk("burst_busy", busy, 1);
        addr = 26'h104; tick();
        addr = 26'h108; tick();
        chk("burst_rd_mid", rd_cnt, 0);
        addr = 26'h10C; cti = 3'b111; tick();
        bus_idle();
        chk("burst_rd", rd_cnt, 1);
        chk("burst_beat", beat_cnt, 4);
        chk("burst_err", err, 0);
        chk("burst_busy_end", busy, 0);
        tick();

        // Same burst, third beat at the wrong address
        cyc = 1'b1; stb = 1'b1; ack = 1'b1; cti = 3'b010;
        addr = 26'h100; tick();
        addr = 26'h104; tick();
        addr = 26'h10C; tick();
        addr = 26'h10C; cti = 3'b111; tick();
        bus_idle();
        chk("badaddr_err", err, 1);
        chk("badaddr_code", code, 3);
        chk("badaddr_rd", rd_cnt, 2);
        chk("badaddr_beat", beat_cnt, 8);
        tick();
        do_clr();
        chk("clr_err", err, 0);

        // Address changes while a request waits for ack -> code 2
        cyc = 1'b1; stb = 1'b1; addr = 26'h400; tick();
        addr = 26'h404; tick();
        bus_idle(); tick();
        chk("chg_code", code, 2);
        chk("chg_busy", busy, 0);
        chk("chg_rd", rd_cnt, 0);
        do_clr();

        // cyc dropped before the end beat of a burst -> code 4
        cyc = 1'b1; stb = 1'b1; ack = 1'b1; cti = 3'b010; addr = 26'h0; tick();
        bus_idle(); tick();
        chk("drop_code", code, 4);
        chk("drop_rd", rd_cnt, 0);
        chk("drop_busy", busy, 0);
        do_clr();

        // Hung request: timeout asserted on the 256th edge after the request starts
        cyc = 1'b1; stb = 1'b1; we = 1'b0; addr = 26'h300;
        repeat (255) tick();
        chk("pre_timeout", tmo, 0);
        chk("pre_timeout_busy", busy, 1);
        tick();
        chk("timeout", tmo, 1);
        repeat (4) tick();
        chk("hung_err_pre", err, 0);
        ack = 1'b1; tick();
        ack = 1'b0;
        chk("late_ack_code", code, 1);
        chk("late_ack_rd", rd_cnt, 0);
        chk("late_ack_beat", beat_cnt, 0);
        chk("hung_busy", busy, 1);
        bus_idle(); tick();
        chk("hung_exit_busy", busy, 0);
        chk("timeout_sticky", tmo, 1);
        chk("hung_lat_last", lat_last, 0);
        do_clr();
        chk("clr_timeout", tmo, 0);

        // SDRAM commands: 3 ACTIVATE, 2 REFRESH, READ while idle
        sd_cmd(3'b011); sd_cmd(3'b011); sd_cmd(3'b011);
        sd_cmd(3'b001); sd_cmd(3'b001);
        sd_cmd(3'b000);
        chk("sd_err_pre", err, 0);
        sd_cmd(3'b101);
        chk("sd_act", act_cnt, 3);
        chk("sd_ref", ref_cnt, 2);
        chk("sd_code", code, 5);
        do_clr();

        // The same events coincident with clr leave everything at zero
        clr = 1'b1;
        sd_cmd(3'b011); sd_cmd(3'b001); sd_cmd(3'b101);
        clr = 1'b0;
        tick();
        chk("clr_act", act_cnt, 0);
        chk("clr_ref", ref_cnt, 0);
        chk("clr_sd_err", err, 0);
        chk("clr_sd_code", code, 0);

        // Stray ack together with an idle WRITE command: lowest code wins
        ack = 1'b1; sd_en = 1'b1; {ras_n, cas_n, we_n} = 3'b100;
        tick();
        ack = 1'b0; sd_en = 1'b0; {ras_n, cas_n, we_n} = 3'b111;
        chk("prio_code", code, 1);
        do_clr();

        // 17 zero-wait reads: the 4-bit instance saturates at 15
        cyc = 1'b1; stb = 1'b1; we = 1'b0; ack = 1'b1; addr = 26'h500;
        repeat (15) tick();
        chk("sat_rd15", s_rd, 15);
        repeat (2) tick();
        bus_idle();
        chk("sat_rd", s_rd, 15);
        chk("sat_beat", s_beat, 15);
        chk("full_rd", rd_cnt, 17);
        chk("sat_err", err, 0);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wb_sdram_txn_monitor.md
Name: wb_sdram_txn_monitor

Overview:
- Parametrised whitebox monitor for the SDRAM controller. It passively observes the Wishbone slave port and the SDRAM command pins.
- Tracks transactions through an FSM and counts reads, writes, burst beats and SDRAM commands.
- Measures request-to-ack latency and flags Wishbone protocol violations and hung requests.
- Instantiated in the verification top. It is read by the scoreboard and assertions and never drives the DUT.

Parameters:
AW, 26, Wishbone address width
DW, 32, Wishbone data width (multiple of 8); burst address stride = DW/8
CNT_W, 16, width of every event counter
LAT_W, 10, width of latency registers
TIMEOUT, 256, cycles without ack before a request is declared hung (1 to 2**LAT_W-1)

Ports:
wb_clk_i  in  1  monitor clock; SDRAM command pins are sampled on this clock (matched-clock integration)
wb_rst_i  in  1  asynchronous active-low reset
clr_i  in  1  synchronous clear of counters, latency and sticky flags
wb_cyc_i  in  1  observed cycle
wb_stb_i  in  1  observed strobe
wb_we_i  in  1  observed write enable
wb_ack_o  in  1  observed slave ack (DUT output)
wb_cti_i  in  3  observed cycle type
wb_addr_i  in  AW  observed address
wb_sel_i  in  DW/8  observed byte selects
sdram_en  in  1  SDRAM command valid
sdram_ras_n  in  1  observed RAS_n
sdram_cas_n  in  1  observed CAS_n
sdram_we_n  in  1  observed WE_n
rd_cnt_o  out  CNT_W  completed Wishbone read transactions
wr_cnt_o  out  CNT_W  completed Wishbone write transactions
beat_cnt_o  out  CNT_W  acked beats (all types)
act_cnt_o  out  CNT_W  SDRAM ACTIVATE commands
ref_cnt_o  out  CNT_W  SDRAM AUTO-REFRESH commands
lat_last_o  out  LAT_W  latency of most recent first beat
lat_max_o  out  LAT_W  maximum first-beat latency since reset/clear
busy_o  out  1  FSM not in IDLE
timeout_o  out  1  sticky hung-request flag
err_o  out  1  sticky protocol-error flag
err_code_o  out  3  code of first error since reset/clear

Behaviour:
- Reset (wb_rst_i=0, async): all outputs 0, FSM IDLE, internal latency counter 0 and address/control snapshot cleared.
- Reset mid-transaction abandons the transaction with no count.
- Register semantics:
  - Every output is registered and updates the cycle after the event.
  - Counters and latency saturate at all-ones and never wrap.
  - clr_i has priority over any event in the same cycle. clr_i does not change FSM state.
- req = wb_cyc_i & wb_stb_i.
- FSM IDLE:
  - On req, go to REQ, snapshot addr/we/sel, and set latency to 1.
  - If wb_ack_o is also high (zero-wait ack), handle the beat as in REQ this same cycle; latency = 1.
- FSM REQ:
  - Latency increments each cycle without ack.
  - On ack: lat_last_o <= latency, update lat_max_o, beat_cnt_o+1.
  - If cti=3'b010, go to BURST with expected next addr = addr + DW/8.
  - Otherwise the transaction completes: rd_cnt_o or wr_cnt_o +1 per snapshot we, then go to IDLE (or REQ if req stays high with a new request).
  - When latency reaches TIMEOUT without ack: timeout_o <= 1, go to HUNG.
- FSM BURST:
  - Each ack increments beat_cnt_o. Expected addr advances by DW/8 (mod 2**AW).
  - On an acked beat with cti=3'b111, the transaction completes and rd/wr counts +1 once per burst.
  - wb_cyc_i=0 before the end beat raises error 4, counts nothing, and returns to IDLE.
- FSM HUNG: stays until wb_cyc_i=0, then IDLE. A late ack in HUNG raises error 1 and is not counted.
- Error codes:
  - 1: ack while !req.
  - 2: addr/we/sel change while req held without ack.
  - 3: burst beat address differs from expected.
  - 4: early cyc drop in burst.
  - 5: SDRAM READ/WRITE command with no open transaction (FSM IDLE).
  - err_o is sticky. err_code_o keeps the first code. For simultaneous errors the lowest code wins.
- SDRAM decode (when sdram_en=1), {ras_n,cas_n,we_n}:
  - 011 = ACTIVATE (act_cnt_o+1).
  - 001 = REFRESH (ref_cnt_o+1).
  - 101 = READ and 100 = WRITE (used for error 5 only).
  - Other codes are ignored.

Test Plan:
- Reset mid-REQ (latency=5): async assert -> all outputs 0 immediately, busy_o=0. After release, the next single read acked after 3 cycles -> rd_cnt_o=1, lat_last_o=3.
- Single write, ack same cycle as stb (cti=000) -> wr_cnt_o=1, beat_cnt_o=1, lat_last_o=1, busy_o back to 0 next cycle.
- 4-beat incrementing read burst at 0x100 (DW=32: addrs 0x100, 0x104, 0x108, 0x10C, last cti=111) -> rd_cnt_o=1, beat_cnt_o=4, err_o=0. Repeat with third beat addr 0x10C -> err_o=1, err_code_o=3.
- No ack for TIMEOUT=256 cycles -> timeout_o=1 at cycle 256, FSM HUNG. Ack at cycle 260 -> err_code_o=1, no counts. cyc drop -> busy_o=0.
- SDRAM: 3 ACTIVATE + 2 REFRESH, plus one READ command while IDLE -> act_cnt_o=3, ref_cnt_o=2, err_code_o=5. Same cycle as clr_i -> all remain 0.
- Counter saturation with CNT_W=4: 17 single reads -> rd_cnt_o=15, no wrap.
